// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, slow-unit
// results wait in a 2-entry FIFO, and a starvation counter forces a drain.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        slow_valid,
  output logic        slow_ready,
  input  logic [4:0]  slow_rd,
  input  logic [31:0] slow_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [31:0] pending_mask
);

  typedef enum logic {NORMAL, FORCE} state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_t      state, state_next;
  logic [4:0]  fifo_rd   [2];
  logic [31:0] fifo_data [2];
  logic        wptr, rptr;
  logic [1:0]  count;
  logic [3:0]  starve, starve_next;
  logic        fifo_empty, push, pop, pipe_use;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_empty = (count == 2'd0);
  assign slow_ready = (count != 2'd2);
  assign push       = slow_valid & slow_ready;
  assign pipe_stall = (state == FORCE);
  assign pipe_use   = pipe_we & (pipe_rd != 5'd0) & ~pipe_stall;
  assign head_rd    = fifo_rd[rptr];
  assign head_data  = fifo_data[rptr];

  always_comb begin
    state_next  = state;
    starve_next = starve;
    pop         = 1'b0;
    rf_we       = 1'b0;
    rf_rd       = 5'd0;
    rf_wdata    = 32'd0;
    case (state)
      FORCE: begin
        pop        = ~fifo_empty;
        rf_we      = ~fifo_empty & (head_rd != 5'd0);
        rf_rd      = head_rd;
        rf_wdata   = head_data;
        state_next = NORMAL;
      end
      default: begin
        if (pipe_use) begin
          rf_we    = 1'b1;
          rf_rd    = pipe_rd;
          rf_wdata = pipe_data;
          if (!fifo_empty) begin
            if (starve == STARVE_LAST) begin
              state_next  = FORCE;
              starve_next = 4'd0;
            end else begin
              starve_next = starve + 4'd1;
            end
          end
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          rf_we    = (head_rd != 5'd0);
          rf_rd    = head_rd;
          rf_wdata = head_data;
        end
      end
    endcase
    if (pop) starve_next = 4'd0;
    // Reset must silence the write port immediately, even with pipe_we high.
    if (rst) rf_we = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= NORMAL;
      starve <= 4'd0;
      count  <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: validity lives entirely in count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= slow_rd;
      fifo_data[wptr] <= slow_data;
    end
  end

  always_comb begin
    pending_mask = 32'd0;
    if (count != 2'd0) pending_mask[head_rd] = 1'b1;
    if (count == 2'd2) pending_mask[fifo_rd[~rptr]] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  force_nonempty: assert property (@(posedge clk) disable iff (rst)
    (state == FORCE) |-> (count != 2'd0));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios from the test
// plan plus a randomized run against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = 5'd0;
  logic [31:0] pipe_data = 32'd0;
  logic        pipe_stall;
  logic        slow_valid = 1'b0;
  logic        slow_ready;
  logic [4:0]  slow_rd = 5'd0;
  logic [31:0] slow_data = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t q[$];

  wb_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .slow_valid(slow_valid), .slow_ready(slow_ready),
    .slow_rd(slow_rd), .slow_data(slow_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    slow_valid = 1'b0; slow_rd = 5'd0; slow_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Applies one cycle of inputs at the falling edge and lets outputs settle.
  task automatic cyc(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                     input logic sv, input logic [4:0] srd, input logic [31:0] sd);
    @(negedge clk);
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    slow_valid = sv; slow_rd = srd; slow_data = sd;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h1234;
    slow_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", pipe_stall); end
    checks++; if (slow_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", slow_ready); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL reset_mask got=%h exp=0", pending_mask); end
    do_reset();
  endtask

  task automatic test_drain();
    do_reset();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD0005);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_we got=%b exp=0", rf_we); end
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("[TB] FAIL drain_we got=%b exp=1", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("[TB] FAIL drain_rd got=%0d exp=5", rf_rd); end
    checks++; if (rf_wdata !== 32'hDEAD0005) begin errors++; $display("[TB] FAIL drain_data got=%h exp=DEAD0005", rf_wdata); end
    checks++; if (pending_mask !== 32'h20) begin errors++; $display("[TB] FAIL drain_mask got=%h exp=00000020", pending_mask); end
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL drain_after_we got=%b exp=0", rf_we); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL drain_after_mask got=%h exp=0", pending_mask); end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 5'd3, 32'h33 + i, 1'b0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin errors++; $display("[TB] FAIL prio_rd cyc=%0d got we=%b rd=%0d exp we=1 rd=3", i, rf_we, rf_rd); end
      checks++; if (pending_mask !== 32'h80) begin errors++; $display("[TB] FAIL prio_mask cyc=%0d got=%h exp=00000080", i, pending_mask); end
      checks++; if (slow_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_ready cyc=%0d got=%b exp=1", i, slow_ready); end
    end
  endtask

  task automatic test_starvation();
    do_reset();
    cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'h77);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      cyc(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
      checks++; if (pipe_stall !== 1'b0 || rf_rd !== 5'd4) begin errors++; $display("[TB] FAIL starve_win cyc=%0d got stall=%b rd=%0d exp stall=0 rd=4", i, pipe_stall, rf_rd); end
    end
    cyc(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL starve_stall got=%b exp=1", pipe_stall); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77) begin errors++; $display("[TB] FAIL starve_force got we=%b rd=%0d data=%h exp we=1 rd=7 data=77", rf_we, rf_rd, rf_wdata); end
    cyc(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    checks++; if (pipe_stall !== 1'b0 || rf_we !== 1'b1 || rf_rd !== 5'd4) begin errors++; $display("[TB] FAIL starve_resume got stall=%b we=%b rd=%0d exp stall=0 we=1 rd=4", pipe_stall, rf_we, rf_rd); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h11);
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd2, 32'h22);
    checks++; if (slow_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one got=%b exp=1", slow_ready); end
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    checks++; if (slow_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got=%b exp=0", slow_ready); end
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    checks++; if (pipe_stall !== 1'b1 || rf_rd !== 5'd1 || slow_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_force got stall=%b rd=%0d ready=%b exp stall=1 rd=1 ready=0", pipe_stall, rf_rd, slow_ready); end
    cyc(1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33);
    checks++; if (slow_ready !== 1'b1 || rf_rd !== 5'd10) begin errors++; $display("[TB] FAIL bp_reopen got ready=%b rd=%0d exp ready=1 rd=10", slow_ready, rf_rd); end
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h22) begin errors++; $display("[TB] FAIL bp_order2 got we=%b rd=%0d data=%h exp we=1 rd=2 data=22", rf_we, rf_rd, rf_wdata); end
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin errors++; $display("[TB] FAIL bp_order3 got we=%b rd=%0d data=%h exp we=1 rd=3 data=33", rf_we, rf_rd, rf_wdata); end
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty got=%b exp=0", rf_we); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_silent got=%b exp=0", rf_we); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL zero_mask got=%h exp=0", pending_mask); end
    cyc(1'b1, 5'd0, 32'hF0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h99) begin errors++; $display("[TB] FAIL zero_drain got we=%b rd=%0d data=%h exp we=1 rd=9 data=99", rf_we, rf_rd, rf_wdata); end
    cyc(1'b1, 5'd0, 32'hF0, 1'b0, 5'd0, 32'd0);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL zero_pipe got=%b exp=0", rf_we); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, 5'd12, 32'hC0, 1'b1, 5'd20, 32'h20);
    cyc(1'b1, 5'd12, 32'hC0, 1'b1, 5'd21, 32'h21);
    cyc(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'd0);
    checks++; if (pending_mask !== 32'h0030_0000 || slow_ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_pre got mask=%h ready=%b exp mask=00300000 ready=0", pending_mask, slow_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL areset_mask got=%h exp=0", pending_mask); end
    checks++; if (slow_ready !== 1'b1 || pipe_stall !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL areset_outs got ready=%b stall=%b we=%b exp 1 0 0", slow_ready, pipe_stall, rf_we); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      checks++; if (rf_we !== 1'b0 || pending_mask !== 32'd0) begin errors++; $display("[TB] FAIL areset_after cyc=%0d got we=%b mask=%h exp we=0 mask=0", i, rf_we, pending_mask); end
    end
  endtask

  // Reference model: a queue of pending results, a forced-drain flag and a
  // count of consecutive losses by a waiting result.
  task automatic test_random();
    logic        m_force, nxt_force, use_m, pop_m, push_m;
    int          m_starve;
    logic        e_we, e_ready;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_mask;
    do_reset();
    q.delete();
    m_force = 1'b0;
    m_starve = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!m_force) begin
        pipe_we   = ($urandom_range(0, 3) != 0);
        pipe_rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        pipe_data = $urandom;
      end
      slow_valid = ($urandom_range(0, 2) == 0);
      slow_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      slow_data  = $urandom;

      e_ready = (q.size() < 2);
      e_mask  = 32'd0;
      foreach (q[k]) e_mask[q[k].rd] = 1'b1;
      e_mask[0] = 1'b0;
      use_m = pipe_we && (pipe_rd != 5'd0) && !m_force;
      pop_m = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0;
      if ((m_force || !use_m) && q.size() > 0) begin
        pop_m  = 1'b1;
        e_we   = (q[0].rd != 5'd0);
        e_rd   = q[0].rd;
        e_data = q[0].data;
      end else if (use_m) begin
        e_we = 1'b1; e_rd = pipe_rd; e_data = pipe_data;
      end
      #1;
      checks++; if (rf_we !== e_we) begin errors++; $display("[TB] FAIL rand_we cyc=%0d got=%b exp=%b", n, rf_we, e_we); end
      if (e_we) begin
        checks++; if (rf_rd !== e_rd || rf_wdata !== e_data) begin errors++; $display("[TB] FAIL rand_write cyc=%0d got rd=%0d data=%h exp rd=%0d data=%h", n, rf_rd, rf_wdata, e_rd, e_data); end
      end
      checks++; if (pipe_stall !== m_force) begin errors++; $display("[TB] FAIL rand_stall cyc=%0d got=%b exp=%b", n, pipe_stall, m_force); end
      checks++; if (slow_ready !== e_ready) begin errors++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", n, slow_ready, e_ready); end
      checks++; if (pending_mask !== e_mask) begin errors++; $display("[TB] FAIL rand_mask cyc=%0d got=%h exp=%h", n, pending_mask, e_mask); end

      nxt_force = 1'b0;
      if (!m_force && use_m && q.size() > 0) begin
        if (m_starve + 1 == STARVE_LIMIT) begin
          nxt_force = 1'b1;
          m_starve = 0;
        end else begin
          m_starve++;
        end
      end
      if (pop_m) m_starve = 0;
      push_m = slow_valid && e_ready;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back('{rd: slow_rd, data: slow_data});
      m_force = nxt_force;
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_priority();
    test_starvation();
    test_backpressure();
    test_zero_reg();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
